// File: rtl/smi_self_word_packer.sv
// -----------------------------------------------------------------------------
// smi_self_word_packer
//
// Packs narrow SELF-handshake words into wide multi-lane words. Up to
// PackFactor input words are gathered into an assembly register; the word is
// closed when the last lane is filled or when an end-of-frame word arrives.
// The packed word is presented through a registered SELF output.
//
// Optional feature: define SMI_WORD_PACKER_TIMEOUT_EN to add an idle counter
// that flushes a partial word (eof=0) after TimeoutCycles idle cycles.
// Without the macro a partial word is held until it fills or eof arrives.
//
// Ports:
//   clk             clock, all state on rising edge
//   srst            synchronous active-high reset
//   dataInValid_i   upstream word valid
//   dataIn_i        upstream word (DataWidth)
//   dataInEof_i     upstream word is last of frame
//   dataInStop_o    upstream stall
//   dataOutValid_o  packed word valid
//   dataOut_o       packed word, lane 0 in bits [DataWidth-1:0]
//   dataOutCount_o  number of valid lanes, 1..PackFactor
//   dataOutEof_o    packed word closes a frame
//   dataOutStop_i   downstream stall
// -----------------------------------------------------------------------------
module smi_self_word_packer #(
  parameter int DataWidth     = 16,
  parameter int PackFactor    = 4,
  parameter int CountWidth    = 3,
  parameter int TimeoutCycles = 15
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic                            dataInValid_i,
  input  logic [DataWidth-1:0]            dataIn_i,
  input  logic                            dataInEof_i,
  output logic                            dataInStop_o,
  output logic                            dataOutValid_o,
  output logic [DataWidth*PackFactor-1:0] dataOut_o,
  output logic [CountWidth-1:0]           dataOutCount_o,
  output logic                            dataOutEof_o,
  input  logic                            dataOutStop_i
);

  localparam int IdxW  = $clog2(PackFactor);
  localparam int WordW = DataWidth * PackFactor;

  logic [WordW-1:0]      asm_q, asm_d;
  logic [WordW-1:0]      asm_merged;
  logic [IdxW-1:0]       lane_idx_q, lane_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [WordW-1:0]      out_data_q, out_data_d;
  logic [CountWidth-1:0] out_count_q, out_count_d;
  logic                  out_eof_q, out_eof_d;

  logic out_free;
  logic accept;
  logic complete;
  logic flush;
  logic load;

  // Stall is purely combinational from the downstream stop so a draining
  // output never costs an input cycle.
  assign dataInStop_o = srst | (out_valid_q & dataOutStop_i);
  assign out_free     = ~out_valid_q | ~dataOutStop_i;
  assign accept       = dataInValid_i & ~dataInStop_o;
  assign complete     = accept & ((lane_idx_q == IdxW'(PackFactor - 1)) | dataInEof_i);

  // Assembly contents including the word accepted this cycle. Lanes above
  // lane_idx_q are always zero because the assembly clears on every load,
  // so this vector can be copied straight into the output register.
  generate
    for (genvar gi = 0; gi < PackFactor; gi++) begin : g_lane
      assign asm_merged[gi*DataWidth +: DataWidth] =
        (accept && (lane_idx_q == IdxW'(gi))) ? dataIn_i
                                              : asm_q[gi*DataWidth +: DataWidth];
    end
  endgenerate

`ifdef SMI_WORD_PACKER_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (accept || (lane_idx_q == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != 8'(TimeoutCycles)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // An accept in the same cycle always wins over a pending flush.
  assign flush = (idle_cnt_q == 8'(TimeoutCycles)) & out_free & ~accept &
                 (lane_idx_q != '0);
`else
  logic [7:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 8'(TimeoutCycles);
  assign flush = 1'b0;
`endif

  assign load = complete | flush;

  always_comb begin
    asm_d       = asm_merged;
    lane_idx_d  = lane_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_eof_d   = out_eof_q;

    if (accept) begin
      lane_idx_d = lane_idx_q + IdxW'(1);
    end

    if (load) begin
      asm_d       = '0;
      lane_idx_d  = '0;
      // A load may coincide with a drain: the new word simply replaces it.
      out_valid_d = 1'b1;
      out_data_d  = asm_merged;
      // A flush carries only the lanes already held; a completion adds one.
      out_count_d = flush ? CountWidth'(lane_idx_q)
                          : CountWidth'(lane_idx_q) + CountWidth'(1);
      out_eof_d   = complete & dataInEof_i;
    end else if (!dataOutStop_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      asm_q       <= '0;
      lane_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_eof_q   <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      lane_idx_q  <= lane_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign dataOutValid_o = out_valid_q;
  assign dataOut_o      = out_data_q;
  assign dataOutCount_o = out_count_q;
  assign dataOutEof_o   = out_eof_q;

endmodule

// File: tb/tb_smi_self_word_packer.sv
// -----------------------------------------------------------------------------
// Testbench for smi_self_word_packer. A queue-based model of the packing rules
// is stepped on every rising edge and compared with the DUT on every falling
// edge; directed sequences add literal expectations, followed by a randomized
// phase with random stalls, end-of-frame and resets.
// Honours SMI_WORD_PACKER_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_smi_self_word_packer;

  localparam int DW = 16;
  localparam int PF = 4;
  localparam int CW = 3;
  localparam int TO = 15;
  localparam int WW = DW * PF;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          dataInValid = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          dataInEof = 1'b0;
  logic          dataInStop;
  logic          dataOutValid;
  logic [WW-1:0] dataOut;
  logic [CW-1:0] dataOutCount;
  logic          dataOutEof;
  logic          dataOutStop = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smi_self_word_packer #(
    .DataWidth(DW), .PackFactor(PF), .CountWidth(CW), .TimeoutCycles(TO)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .dataInValid_i (dataInValid),
    .dataIn_i      (dataIn),
    .dataInEof_i   (dataInEof),
    .dataInStop_o  (dataInStop),
    .dataOutValid_o(dataOutValid),
    .dataOut_o     (dataOut),
    .dataOutCount_o(dataOutCount),
    .dataOutEof_o  (dataOutEof),
    .dataOutStop_i (dataOutStop)
  );

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid = 1'b0;
  logic [WW-1:0] m_data = '0;
  int            m_count = 0;
  logic          m_eof = 1'b0;
  logic [DW-1:0] part[$];
  int            idle = 0;

  function automatic logic [WW-1:0] pack_part();
    logic [WW-1:0] w = '0;
    foreach (part[i]) w = w | (WW'(part[i]) << (DW * i));
    return w;
  endfunction

  task automatic model_step();
    logic stall;
    logic acc;
    logic ld;
    int   n0;
    if (srst) begin
      m_valid = 1'b0; m_data = '0; m_count = 0; m_eof = 1'b0;
      part.delete(); idle = 0;
      return;
    end
    n0    = part.size();
    stall = m_valid && dataOutStop;
    acc   = dataInValid && !stall;
    ld    = 1'b0;
    if (acc) begin
      part.push_back(dataIn);
      if (part.size() == PF || dataInEof) begin
        m_data = pack_part(); m_count = part.size(); m_eof = dataInEof;
        ld = 1'b1; part.delete();
      end
    end
`ifdef SMI_WORD_PACKER_TIMEOUT_EN
    else if (!stall && n0 > 0 && idle >= TO) begin
      m_data = pack_part(); m_count = n0; m_eof = 1'b0;
      ld = 1'b1; part.delete();
    end
    if (acc || n0 == 0) idle = 0;
    else if (idle < TO) idle++;
`endif
    if (ld) m_valid = 1'b1;
    else if (!dataOutStop) m_valid = 1'b0;
  endtask

  // Single compare process: model steps on the rising edge, compare on falling.
  initial begin
    @(posedge clk);
    forever begin
      model_step();
      @(negedge clk);
      chk("out_valid", WW'(dataOutValid), WW'(m_valid));
      chk("out_data", dataOut, m_data);
      chk("out_count", WW'(dataOutCount), WW'(m_count));
      chk("out_eof", WW'(dataOutEof), WW'(m_eof));
      chk("in_stop", WW'(dataInStop), WW'(srst | (m_valid & dataOutStop)));
      @(posedge clk);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic e);
    int n = 0;
    dataInValid = 1'b1; dataIn = w; dataInEof = e;
    @(negedge clk);
    while (dataInStop && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
    end
    @(posedge clk);
    #1;
    dataInValid = 1'b0; dataInEof = 1'b0;
  endtask

  initial begin
    logic prev_stall;
    bit   seen;
    int   k;

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst_valid", WW'(dataOutValid), '0);
    chk("rst_data", dataOut, '0);
    chk("rst_count", WW'(dataOutCount), '0);
    chk("rst_eof", WW'(dataOutEof), '0);
    chk("rst_stop", WW'(dataInStop), WW'(1));
    cyc();
    srst = 1'b0;

    // Four words back to back, eof on the last
    for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
    @(negedge clk);
    chk("t1_valid", WW'(dataOutValid), WW'(1));
    chk("t1_data", dataOut, 64'h0004_0003_0002_0001);
    chk("t1_count", WW'(dataOutCount), WW'(4));
    chk("t1_eof", WW'(dataOutEof), WW'(1));
    cyc();

    // Short frame
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    @(negedge clk);
    chk("t2_data", dataOut, 64'h0000_0000_BBBB_AAAA);
    chk("t2_count", WW'(dataOutCount), WW'(2));
    chk("t2_eof", WW'(dataOutEof), WW'(1));
    cyc();

    // Eight words, downstream stall for 5 cycles after the first output
    fork
      begin
        for (int i = 0; i < 8; i++) send(DW'(16'h0011 + i), 1'b0);
      end
      begin
        k = 0;
        cyc();
        while (!dataOutValid && k < 50) begin
          cyc();
          k++;
        end
        dataOutStop = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("t3_stall_stop", WW'(dataInStop), WW'(1));
          chk("t3_stall_data", dataOut, 64'h0014_0013_0012_0011);
          cyc();
        end
        dataOutStop = 1'b0;
      end
    join
    @(negedge clk);
    chk("t3_data", dataOut, 64'h0018_0017_0016_0015);
    chk("t3_count", WW'(dataOutCount), WW'(4));
    chk("t3_eof", WW'(dataOutEof), WW'(0));
    cyc();

    // Reset mid-frame discards the partial word
    for (int i = 1; i <= 3; i++) send(DW'(16'h0100 + i), 1'b0);
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    for (int i = 1; i <= 4; i++) send(DW'(16'h0200 + i), i == 4);
    @(negedge clk);
    chk("t4_data", dataOut, 64'h0204_0203_0202_0201);
    chk("t4_count", WW'(dataOutCount), WW'(4));
    cyc();
    cyc();

    // Partial word followed by idle
    send(16'h1234, 1'b0);
`ifdef SMI_WORD_PACKER_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (!seen && k < TO + 10) begin
      @(negedge clk);
      k++;
      seen = dataOutValid;
    end
    chk("t5_latency", WW'(k), WW'(TO + 2));
    chk("t5_data", dataOut, 64'h0000_0000_0000_1234);
    chk("t5_count", WW'(dataOutCount), WW'(1));
    chk("t5_eof", WW'(dataOutEof), WW'(0));
    cyc();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen = seen | dataOutValid;
    end
    chk("t5_no_flush", WW'(seen), WW'(0));
    cyc();
    // Close the held partial word so the random phase starts clean
    send(16'h5678, 1'b1);
    @(negedge clk);
    chk("t5_close", dataOut, 64'h0000_0000_5678_1234);
    cyc();
`endif

    // Randomized phase; valid/data/eof are held while stalled
    prev_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(dataInValid && prev_stall)) begin
        dataInValid = ($urandom % 4) != 0;
        dataIn      = DW'($urandom);
        dataInEof   = ($urandom % 5) == 0;
      end
      dataOutStop = ($urandom % 3) == 0;
      srst        = ($urandom % 300) == 0;
      @(negedge clk);
      prev_stall = dataInStop;
      cyc();
    end
    srst = 1'b0; dataInValid = 1'b0; dataInEof = 1'b0; dataOutStop = 1'b0;
    cyc(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
